// File: rtl/baud_rate_gen.sv
// baud_rate_gen: free-running divide-by-N_COUNT single-cycle tick strobe
module baud_rate_gen #(
    parameter int N_BITS  = 8,
    parameter int N_COUNT = 163
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam logic [N_BITS-1:0] LAST = N_BITS'(N_COUNT - 1);
    if (N_COUNT < 2 || 64'(N_COUNT) > (64'd1 << N_BITS)) begin : g_bad_params
        $error("baud_rate_gen: N_COUNT must lie in 2 .. 2**N_BITS");
    end
    logic [N_BITS-1:0] cnt_q, cnt_d;
    logic              tick_q, tick_d;
    // wrap to zero and raise the strobe on the last count of each period
    always_comb begin
        tick_d = cnt_q == LAST;
        cnt_d  = tick_d ? '0 : cnt_q + N_BITS'(1);
    end
    // counter and registered strobe, cleared by synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end
    assign tick = tick_q;
endmodule

// File: tb/tb_baud_rate_gen.sv
// tb_baud_rate_gen: scoreboard check of tick timing for three divider configurations
module tb_baud_rate_gen;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tick_a, tick_b, tick_c;
    int   total = 0;
    int   bad   = 0;
    int   k     = 0;
    logic [2:0] exp_q[$];

    baud_rate_gen dut_a (.clock(clock), .reset(reset), .tick(tick_a));
    baud_rate_gen #(.N_BITS(1), .N_COUNT(2))   dut_b (.clock(clock), .reset(reset), .tick(tick_b));
    baud_rate_gen #(.N_BITS(8), .N_COUNT(256)) dut_c (.clock(clock), .reset(reset), .tick(tick_c));

    always #10 clock = ~clock;

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic r);
        logic [2:0] e;
        reset = r;
        @(posedge clock);
        k = r ? 0 : k + 1;
        exp_q.push_back({k > 0 && k % 256 == 0, k > 0 && k % 2 == 0, k > 0 && k % 163 == 0});
        #1;
        e = exp_q.pop_front();
        chk($sformatf("n163 k=%0d r=%b", k, r), tick_a, e[0]);
        chk($sformatf("n2 k=%0d r=%b", k, r), tick_b, e[1]);
        chk($sformatf("n256 k=%0d r=%b", k, r), tick_c, e[2]);
    endtask

    initial begin
        repeat (2) cycle(1'b1);
        repeat (1000) cycle(1'b0);
        cycle(1'b1);
        repeat (100) cycle(1'b0);
        cycle(1'b1);
        repeat (200) cycle(1'b0);
        repeat (3) cycle(1'b1);
        repeat (163) cycle(1'b0);
        chk("tick_at_163", tick_a, 1'b1);
        cycle(1'b1);
        repeat (170) cycle(1'b0);
        repeat (600) cycle(1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
